// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the multiplier result collectors.
//   - Collector FSM state encoding (plain constants so legacy code that
//     compares raw state values keeps working).
//   - Default limb address width and the matching maximum limb count.
//   - Control-beat layout: beat 0 carries the unit id in the full control
//     word, beat 1 carries the destination register select in its low bits.
// ----------------------------------------------------------------------------
package mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_GET_DEST = 2'd1;
    localparam state_t ST_COLLECT  = 2'd2;
    localparam state_t ST_FINISH   = 2'd3;

    localparam int unsigned C_ADDR_WIDTH = 9;
    localparam int unsigned C_MAX_LIMBS  = 2 ** C_ADDR_WIDTH;

    // Control-beat positions within a command.
    localparam int unsigned C_BEAT_ID     = 0;
    localparam int unsigned C_BEAT_SELECT = 1;

    // Limb capacity of one destination register for a given address width.
    function automatic int unsigned max_limbs(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/mult_result_collector_limb_nz_tracker.sv
// ----------------------------------------------------------------------------
// limb_nz_tracker
//   Bookkeeping for a limb stream: position counter, index of the most
//   significant non-zero limb seen so far, and an overflow flag for limbs
//   that do not fit in the destination register.
//
// Ports
//   r_clk     clock
//   r_rst     synchronous active-high reset
//   clear     start of a new stream: zero every tracked value
//   step      one limb is being consumed this cycle
//   data_nz   the limb consumed this cycle is non-zero
//   wr_idx    address of the limb consumed this cycle
//   room      current limb still fits (counter below capacity)
//   nz_idx    index of the highest non-zero limb stored so far
//   seen_nz   at least one stored limb was non-zero
//   overflow  at least one limb arrived after the register was full
// ----------------------------------------------------------------------------
module limb_nz_tracker
    import mult_pkg::*;
#(
    parameter int g_addr_width = 9
) (
    input  logic                    r_clk,
    input  logic                    r_rst,
    input  logic                    clear,
    input  logic                    step,
    input  logic                    data_nz,
    output logic [g_addr_width-1:0] wr_idx,
    output logic                    room,
    output logic [g_addr_width-1:0] nz_idx,
    output logic                    seen_nz,
    output logic                    overflow
);

    localparam logic [g_addr_width:0] C_ONE = {{g_addr_width{1'b0}}, 1'b1};

    // One extra bit so the counter can sit at full capacity (2^g_addr_width)
    // and saturate there instead of wrapping back to address 0.
    logic [g_addr_width:0] cnt;

    assign wr_idx = cnt[g_addr_width-1:0];
    assign room   = ~cnt[g_addr_width];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and evaluation order does not matter.
    always_ff @(posedge r_clk) begin
        if (r_rst || clear) begin
            cnt      <= '0;
            nz_idx   <= '0;
            seen_nz  <= 1'b0;
            overflow <= 1'b0;
        end else if (step) begin
            if (room) begin
                cnt <= cnt + C_ONE;
                // Only stored limbs can define the result size, so the
                // recorded index never leaves the register's address range.
                if (data_nz) begin
                    nz_idx  <= cnt[g_addr_width-1:0];
                    seen_nz <= 1'b1;
                end
            end else begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_result_collector.sv
// ----------------------------------------------------------------------------
// mult_result_collector
//   Receiving end of the multiplier result stream. A two-beat control command
//   (unit id, then destination select) arms the collector; each following
//   limb is written into the register bank at consecutive addresses, least
//   significant limb first. At end of stream the normalized size (trailing
//   zero limbs trimmed), a zero flag and an overflow flag are reported.
//
// Ports
//   r_clk            clock
//   r_rst            synchronous active-high reset
//   pi_ctrl_ch       control word (id beat, then select beat)
//   pi_ctrl_valid_n  active-low, marks the id beat of a command
//   pi_data          result limb
//   pi_data_last     final limb of the stream (qualified by pi_data_wr_en)
//   pi_data_wr_en    limb valid
//   po_wr_en         register-bank write strobe (one cycle after the limb)
//   po_wr_addr       limb address within the destination register
//   po_wr_data       limb data
//   po_wr_sel        destination register
//   po_busy          command accepted and stream not yet finished
//   po_done          one-cycle end-of-stream pulse
//   po_size          normalized limb count, held until the next done
//   po_zero          result is zero, held until the next done
//   po_overflow      stream exceeded register capacity, held until next done
// ----------------------------------------------------------------------------
module mult_result_collector
    import mult_pkg::*;
#(
    parameter int g_data_width   = 64,
    parameter int g_addr_width   = 9,
    parameter int g_ctrl_width   = 8,
    parameter int g_select_width = 5,
    parameter int g_id           = 3
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic [g_ctrl_width-1:0]   pi_ctrl_ch,
    input  logic                      pi_ctrl_valid_n,
    input  logic [g_data_width-1:0]   pi_data,
    input  logic                      pi_data_last,
    input  logic                      pi_data_wr_en,
    output logic                      po_wr_en,
    output logic [g_addr_width-1:0]   po_wr_addr,
    output logic [g_data_width-1:0]   po_wr_data,
    output logic [g_select_width-1:0] po_wr_sel,
    output logic                      po_busy,
    output logic                      po_done,
    output logic [g_addr_width:0]     po_size,
    output logic                      po_zero,
    output logic                      po_overflow
);

    localparam logic [g_ctrl_width-1:0] C_ID  = g_ctrl_width'(g_id);
    localparam logic [g_addr_width:0]   C_ONE = {{g_addr_width{1'b0}}, 1'b1};

    state_t                    state;
    logic [g_select_width-1:0] sel;

    logic                      trk_clear;
    logic                      trk_step;
    logic [g_addr_width-1:0]   trk_wr_idx;
    logic                      trk_room;
    logic [g_addr_width-1:0]   trk_nz_idx;
    logic                      trk_seen_nz;
    logic                      trk_overflow;

    // Tracker is cleared while the destination is latched, and advances on
    // every valid limb in COLLECT (including ones past capacity).
    assign trk_clear = (state == ST_GET_DEST);
    assign trk_step  = (state == ST_COLLECT) && pi_data_wr_en;

    limb_nz_tracker #(
        .g_addr_width (g_addr_width)
    ) u_tracker (
        .r_clk    (r_clk),
        .r_rst    (r_rst),
        .clear    (trk_clear),
        .step     (trk_step),
        .data_nz  (|pi_data),
        .wr_idx   (trk_wr_idx),
        .room     (trk_room),
        .nz_idx   (trk_nz_idx),
        .seen_nz  (trk_seen_nz),
        .overflow (trk_overflow)
    );

    // NOTE: reset is synchronous, so it is simply the highest-priority branch
    // inside the clocked block; r_rst is not in the sensitivity list.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state       <= ST_IDLE;
            sel         <= '0;
            po_wr_en    <= 1'b0;
            po_wr_addr  <= '0;
            po_wr_data  <= '0;
            po_wr_sel   <= '0;
            po_busy     <= 1'b0;
            po_done     <= 1'b0;
            po_size     <= '0;
            po_zero     <= 1'b0;
            po_overflow <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            po_wr_en <= 1'b0;
            po_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Id beat; commands for other units are ignored.
                    if (!pi_ctrl_valid_n && (pi_ctrl_ch == C_ID)) begin
                        state <= ST_GET_DEST;
                    end
                end

                ST_GET_DEST: begin
                    // Select beat follows the id beat unconditionally.
                    sel     <= pi_ctrl_ch[g_select_width-1:0];
                    po_busy <= 1'b1;
                    state   <= ST_COLLECT;
                end

                ST_COLLECT: begin
                    if (pi_data_wr_en) begin
                        if (trk_room) begin
                            po_wr_en   <= 1'b1;
                            po_wr_addr <= trk_wr_idx;
                            po_wr_data <= pi_data;
                            po_wr_sel  <= sel;
                        end
                        if (pi_data_last) begin
                            state <= ST_FINISH;
                        end
                    end
                end

                ST_FINISH: begin
                    // Tracker already includes the final limb here.
                    po_done     <= 1'b1;
                    po_size     <= trk_seen_nz ? ({1'b0, trk_nz_idx} + C_ONE) : C_ONE;
                    po_zero     <= ~trk_seen_nz;
                    po_overflow <= trk_overflow;
                    po_busy     <= 1'b0;
                    state       <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_collector.sv
module tb_mult_result_collector;

    localparam int DW  = 64;
    localparam int AW  = 9;
    localparam int CW  = 8;
    localparam int SW  = 5;
    localparam int ID  = 3;
    localparam int CAP = 1 << AW;

    typedef logic [DW-1:0] limb_q_t[$];

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [CW-1:0] pi_ctrl_ch;
    logic          pi_ctrl_valid_n;
    logic [DW-1:0] pi_data;
    logic          pi_data_last;
    logic          pi_data_wr_en;
    logic          po_wr_en;
    logic [AW-1:0] po_wr_addr;
    logic [DW-1:0] po_wr_data;
    logic [SW-1:0] po_wr_sel;
    logic          po_busy;
    logic          po_done;
    logic [AW:0]   po_size;
    logic          po_zero;
    logic          po_overflow;

    int n_vec = 0;
    int n_err = 0;

    mult_result_collector #(
        .g_data_width   (DW),
        .g_addr_width   (AW),
        .g_ctrl_width   (CW),
        .g_select_width (SW),
        .g_id           (ID)
    ) dut (
        .r_clk           (r_clk),
        .r_rst           (r_rst),
        .pi_ctrl_ch      (pi_ctrl_ch),
        .pi_ctrl_valid_n (pi_ctrl_valid_n),
        .pi_data         (pi_data),
        .pi_data_last    (pi_data_last),
        .pi_data_wr_en   (pi_data_wr_en),
        .po_wr_en        (po_wr_en),
        .po_wr_addr      (po_wr_addr),
        .po_wr_data      (po_wr_data),
        .po_wr_sel       (po_wr_sel),
        .po_busy         (po_busy),
        .po_done         (po_done),
        .po_size         (po_size),
        .po_zero         (po_zero),
        .po_overflow     (po_overflow)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle_inputs();
        pi_ctrl_ch      = '0;
        pi_ctrl_valid_n = 1'b1;
        pi_data         = '0;
        pi_data_last    = 1'b0;
        pi_data_wr_en   = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_wr_en"},    DW'(po_wr_en),    '0);
        check({tag, "_wr_addr"},  DW'(po_wr_addr),  '0);
        check({tag, "_wr_data"},  po_wr_data,       '0);
        check({tag, "_wr_sel"},   DW'(po_wr_sel),   '0);
        check({tag, "_busy"},     DW'(po_busy),     '0);
        check({tag, "_done"},     DW'(po_done),     '0);
        check({tag, "_size"},     DW'(po_size),     '0);
        check({tag, "_zero"},     DW'(po_zero),     '0);
        check({tag, "_overflow"}, DW'(po_overflow), '0);
    endtask

    // Two-beat command; afterwards busy reflects whether it was accepted.
    task automatic send_cmd(input logic [CW-1:0] id, input logic [CW-1:0] sel_beat);
        pi_ctrl_valid_n = 1'b0;
        pi_ctrl_ch      = id;
        tick();
        pi_ctrl_valid_n = 1'b1;
        pi_ctrl_ch      = sel_beat;
        tick();
        pi_ctrl_ch      = '0;
        check("cmd_busy", DW'(po_busy), DW'(id == CW'(ID)));
    endtask

    // Drive a limb stream and check every cycle against the reference rules:
    // the first CAP limbs are stored at address = position, and the result
    // size is one past the highest non-zero stored limb (1 if none).
    task automatic run_stream(input limb_q_t limbs, input logic [SW-1:0] sel,
                              input bit accept, input int gap_every, input bit rand_gaps);
        int n = limbs.size();
        int last_nz = -1;
        int writes = 0;
        int exp_size;
        for (int i = 0; i < n && i < CAP; i++) begin
            if (limbs[i] != '0) last_nz = i;
        end
        exp_size = (last_nz < 0) ? 1 : last_nz + 1;

        for (int i = 0; i < n; i++) begin
            if ((gap_every > 0 && i % gap_every == gap_every - 1) ||
                (rand_gaps && $urandom_range(0, 2) == 0)) begin
                pi_data_wr_en = 1'b0;
                pi_data       = {$urandom, $urandom};
                pi_data_last  = 1'($urandom_range(0, 1));
                tick();
                check("gap_wr_en", DW'(po_wr_en), '0);
            end
            pi_data_wr_en = 1'b1;
            pi_data       = limbs[i];
            pi_data_last  = (i == n - 1);
            tick();
            if (po_wr_en === 1'b1) writes++;
            check("beat_wr_en", DW'(po_wr_en), DW'(accept && i < CAP));
            if (accept && i < CAP) begin
                check("beat_addr", DW'(po_wr_addr), DW'(i));
                check("beat_data", po_wr_data, limbs[i]);
                check("beat_sel",  DW'(po_wr_sel), DW'(sel));
            end
            if (i < n - 1 || gap_every > 0) begin
                check("beat_done", DW'(po_done), '0);
                check("beat_busy", DW'(po_busy), DW'(accept));
            end
        end
        idle_inputs();
        check("write_count", DW'(writes), DW'(accept ? ((n < CAP) ? n : CAP) : 0));
        check("pre_done", DW'(po_done), '0);
        tick();
        check("done", DW'(po_done), DW'(accept));
        check("post_busy", DW'(po_busy), '0);
        if (accept) begin
            check("size",     DW'(po_size),     DW'(exp_size));
            check("zero",     DW'(po_zero),     DW'(last_nz < 0));
            check("overflow", DW'(po_overflow), DW'(n > CAP));
            tick();
            check("done_pulse", DW'(po_done), '0);
            check("size_hold",  DW'(po_size), DW'(exp_size));
        end
    endtask

    initial begin
        limb_q_t q;
        logic [SW-1:0] rsel;

        idle_inputs();
        r_rst = 1'b1;
        tick();
        tick();
        check_all_clear("reset");
        r_rst = 1'b0;
        tick();

        // Basic 3-limb stream, select 5.
        send_cmd(8'd3, 8'd5);
        q = '{64'h1, 64'h2, 64'h3};
        run_stream(q, 5'd5, 1'b1, 0, 1'b0);

        // Trailing zeros trimmed.
        send_cmd(8'd3, 8'd5);
        q = '{64'hA, 64'h0, 64'h0};
        run_stream(q, 5'd5, 1'b1, 0, 1'b0);

        // Single zero limb.
        send_cmd(8'd3, 8'd9);
        q = '{64'h0};
        run_stream(q, 5'd9, 1'b1, 0, 1'b0);

        // Wrong id: stream is dropped.
        send_cmd(8'd2, 8'd5);
        q = '{64'h11, 64'h22, 64'h33};
        run_stream(q, 5'd5, 1'b0, 0, 1'b0);

        // Select beat upper bits are not part of the select.
        send_cmd(8'd3, 8'hE7);
        q = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        run_stream(q, 5'd7, 1'b1, 0, 1'b0);

        // Overflow: 514 non-zero limbs with a gap every 3rd beat.
        send_cmd(8'd3, 8'd17);
        q = {};
        for (int i = 0; i < CAP + 2; i++) q.push_back(DW'(i + 1));
        run_stream(q, 5'd17, 1'b1, 3, 1'b0);

        // Reset mid-stream abandons the transfer.
        send_cmd(8'd3, 8'd4);
        pi_data_wr_en = 1'b1;
        pi_data       = 64'h5;
        tick();
        check("rst_pre_wr1", DW'(po_wr_addr), '0);
        pi_data       = 64'h6;
        tick();
        check("rst_pre_wr2", DW'(po_wr_addr), 64'd1);
        idle_inputs();
        r_rst = 1'b1;
        tick();
        check_all_clear("midrst");
        r_rst = 1'b0;
        tick();
        check("midrst_no_done", DW'(po_done), '0);
        send_cmd(8'd3, 8'd4);
        q = '{64'h7};
        run_stream(q, 5'd4, 1'b1, 0, 1'b0);

        // Randomized transfers against the reference rules.
        for (int t = 0; t < 12; t++) begin
            int n = $urandom_range(1, 9);
            bit ok = ($urandom_range(0, 4) != 0);
            rsel = SW'($urandom);
            send_cmd(ok ? 8'd3 : 8'(($urandom_range(4, 255))), {3'b0, rsel});
            q = {};
            for (int i = 0; i < n; i++) begin
                q.push_back(($urandom_range(0, 2) == 0) ? 64'h0 : {$urandom, $urandom});
            end
            run_stream(q, rsel, ok, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
